// File: rtl/nec_ir_pkg.sv
// Shared definitions for the NEC IR controller.
// Holds the controller state encoding, the NEC command codes understood by the
// LED-effect configuration, the configuration reset defaults and a byte
// bit-reversal helper. NEC sends each byte LSB first, so the receiver delivers
// bytes with the first-received bit at the MSB.
package nec_ir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_APPLY = 2'd2
  } nec_state_e;

  localparam logic [7:0] CMD_POWER     = 8'h45;
  localparam logic [7:0] CMD_BRIGHT_UP = 8'h46;
  localparam logic [7:0] CMD_BRIGHT_DN = 8'h15;
  localparam logic [7:0] CMD_MODE_NEXT = 8'h43;
  localparam logic [7:0] CMD_MODE_PREV = 8'h44;
  localparam logic [7:0] CMD_SPEED_UP  = 8'h40;
  localparam logic [7:0] CMD_SPEED_DN  = 8'h07;

  localparam logic [7:0] BRIGHTNESS_DEFAULT = 8'h80;
  localparam logic [3:0] SPEED_DEFAULT      = 4'd8;

  // Mirror a byte end-for-end (MSB-first receive order back to bit-correct).
  function automatic logic [7:0] reverse8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = b[7 - i];
    end
    return r;
  endfunction

endpackage

// File: rtl/nec_ir_controller_if.sv
// Frame handoff from the NEC IR receiver to the controller.
//   frameValidIN : one-cycle strobe, frame present on frameIN
//   frameIN      : [31:24] addr, [23:16] ~addr, [15:8] cmd, [7:0] ~cmd,
//                  each byte with its first-received bit at the MSB
// master = receiver side (drives), slave = controller side (samples).
interface nec_ir_controller_if;
  logic        frameValidIN;
  logic [31:0] frameIN;

  modport master (output frameValidIN, output frameIN);
  modport slave  (input  frameValidIN, input  frameIN);
endinterface

// File: rtl/ClockDivider.sv
// Free-running divider producing a one-cycle tick every VALUE clkIN cycles.
//   clkIN    : system clock
//   nResetIN : async active-low reset (prescaler cleared to 0)
//   tickOUT  : registered one-cycle tick
module ClockDivider #(
  parameter int VALUE = 50_000
) (
  input  logic clkIN,
  input  logic nResetIN,
  output logic tickOUT
);

  localparam int            W    = (VALUE > 1) ? $clog2(VALUE) : 1;
  localparam logic [W-1:0]  LAST = W'(VALUE - 1);

  logic [W-1:0] count_r;
  logic         tick_r;

  // Prescaler counts 0..VALUE-1 and flags the wrap as the tick.
  always_ff @(posedge clkIN or negedge nResetIN) begin
    if (!nResetIN) begin
      count_r <= '0;
      tick_r  <= 1'b0;
    end else if (count_r == LAST) begin
      count_r <= '0;
      tick_r  <= 1'b1;
    end else begin
      count_r <= count_r + 1'b1;
      tick_r  <= 1'b0;
    end
  end

  assign tickOUT = tick_r;

endmodule

// File: rtl/nec_ir_controller.sv
// NEC key decoder and LED-effect configuration register.
// Validates complement bytes and the device address of each received frame,
// emits key events, tracks key hold / auto-repeat and applies saturating or
// wrapping updates to power, brightness, mode and speed.
//   clkIN, nResetIN   : clock, async active-low reset
//   irBus (slave)     : frame strobe + 32-bit frame
//   keyValidOUT       : one-cycle pulse per accepted key
//   keyCodeOUT        : last accepted command (bit-corrected)
//   keyHeldOUT        : accepted key repeating inside the hold window
//   powerOUT, brightnessOUT, modeOUT, speedOUT : effect configuration
//   configUpdatedOUT  : one-cycle pulse when any config value changed
//   errorCountOUT     : saturating complement-failure count
module nec_ir_controller
  import nec_ir_pkg::*;
#(
  parameter int         CLOCK_KHZ       = 50_000,
  parameter logic [7:0] DEVICE_ADDRESS  = 8'h00,
  parameter int         HOLD_MS         = 120,
  parameter int         BRIGHTNESS_STEP = 16,
  parameter int         MODE_COUNT      = 8
) (
  input  logic                 clkIN,
  input  logic                 nResetIN,
  nec_ir_controller_if.slave   irBus,
  output logic                 keyValidOUT,
  output logic [7:0]           keyCodeOUT,
  output logic                 keyHeldOUT,
  output logic                 powerOUT,
  output logic [7:0]           brightnessOUT,
  output logic [2:0]           modeOUT,
  output logic [3:0]           speedOUT,
  output logic                 configUpdatedOUT,
  output logic [7:0]           errorCountOUT
);

  localparam logic [7:0] HOLD_RELOAD  = 8'(HOLD_MS);
  localparam logic [7:0] STEP8        = 8'(BRIGHTNESS_STEP);
  localparam logic [8:0] STEP9        = 9'(BRIGHTNESS_STEP);
  localparam logic [2:0] MODE_LAST    = 3'(MODE_COUNT - 1);

  nec_state_e  state_r, nextState_s;
  logic [31:0] frame_r;
  logic        latchFrame_s, countError_s, applyKey_s;
  logic [7:0]  addr_s, addrInv_s, cmd_s, cmdInv_s;
  logic        complementBad_s, held_s, configChanged_s, tick_s;
  logic        nextPower_s;
  logic [7:0]  nextBright_s;
  logic [8:0]  brightSum_s;
  logic [2:0]  nextMode_s;
  logic [3:0]  nextSpeed_s;

  logic        keyValid_r, keyHeld_r, power_r, configUpdated_r;
  logic [7:0]  keyCode_r, brightness_r, errorCount_r, holdTimer_r;
  logic [2:0]  mode_r;
  logic [3:0]  speed_r;

  ClockDivider #(.VALUE(CLOCK_KHZ)) msTick (
    .clkIN    (clkIN),
    .nResetIN (nResetIN),
    .tickOUT  (tick_s)
  );

  assign addr_s    = reverse8(frame_r[31:24]);
  assign addrInv_s = reverse8(frame_r[23:16]);
  assign cmd_s     = reverse8(frame_r[15:8]);
  assign cmdInv_s  = reverse8(frame_r[7:0]);
  assign complementBad_s = ((addr_s ^ addrInv_s) != 8'hFF) || ((cmd_s ^ cmdInv_s) != 8'hFF);

  // FSM state register.
  always_ff @(posedge clkIN or negedge nResetIN) begin
    if (!nResetIN) state_r <= ST_IDLE;
    else           state_r <= nextState_s;
  end

  // FSM next-state and control strobes; strobes outside IDLE are dropped.
  always_comb begin
    nextState_s  = state_r;
    latchFrame_s = 1'b0;
    countError_s = 1'b0;
    applyKey_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (irBus.frameValidIN) begin
          latchFrame_s = 1'b1;
          nextState_s  = ST_CHECK;
        end else begin
          nextState_s  = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (complementBad_s) begin
          countError_s = 1'b1;
          nextState_s  = ST_IDLE;
        end else if (addr_s != DEVICE_ADDRESS) begin
          nextState_s  = ST_IDLE;
        end else begin
          nextState_s  = ST_APPLY;
        end
      end
      ST_APPLY: begin
        applyKey_s  = 1'b1;
        nextState_s = ST_IDLE;
      end
      default: nextState_s = ST_IDLE;
    endcase
  end

  // Next configuration for the latched command; power/mode ignore repeats.
  always_comb begin
    held_s       = (cmd_s == keyCode_r) && (holdTimer_r != 8'd0);
    nextPower_s  = power_r;
    nextBright_s = brightness_r;
    nextMode_s   = mode_r;
    nextSpeed_s  = speed_r;
    brightSum_s  = {1'b0, brightness_r} + STEP9;
    if (cmd_s == CMD_POWER) begin
      if (!held_s) nextPower_s = ~power_r;
      else         nextPower_s = power_r;
    end else if (power_r) begin
      case (cmd_s)
        CMD_BRIGHT_UP: nextBright_s = brightSum_s[8] ? 8'hFF : brightSum_s[7:0];
        CMD_BRIGHT_DN: nextBright_s = (brightness_r >= STEP8) ? (brightness_r - STEP8) : 8'h00;
        CMD_MODE_NEXT: begin
          if (!held_s) nextMode_s = (mode_r == MODE_LAST) ? 3'd0 : (mode_r + 3'd1);
          else         nextMode_s = mode_r;
        end
        CMD_MODE_PREV: begin
          if (!held_s) nextMode_s = (mode_r == 3'd0) ? MODE_LAST : (mode_r - 3'd1);
          else         nextMode_s = mode_r;
        end
        CMD_SPEED_UP:  nextSpeed_s = (speed_r == 4'd15) ? 4'd15 : (speed_r + 4'd1);
        CMD_SPEED_DN:  nextSpeed_s = (speed_r == 4'd0) ? 4'd0 : (speed_r - 4'd1);
        default:       nextSpeed_s = speed_r;
      endcase
    end else begin
      nextPower_s = power_r;
    end
    configChanged_s = (nextPower_s != power_r) || (nextBright_s != brightness_r) ||
                      (nextMode_s != mode_r) || (nextSpeed_s != speed_r);
  end

  // Frame capture on an accepted strobe.
  always_ff @(posedge clkIN or negedge nResetIN) begin
    if (!nResetIN)         frame_r <= 32'h0;
    else if (latchFrame_s) frame_r <= irBus.frameIN;
  end

  // Saturating complement-failure counter.
  always_ff @(posedge clkIN or negedge nResetIN) begin
    if (!nResetIN)                                   errorCount_r <= 8'h00;
    else if (countError_s && errorCount_r != 8'hFF)  errorCount_r <= errorCount_r + 8'd1;
  end

  // Key event, pulses and configuration registers.
  always_ff @(posedge clkIN or negedge nResetIN) begin
    if (!nResetIN) begin
      keyValid_r      <= 1'b0;
      configUpdated_r <= 1'b0;
      keyCode_r       <= 8'h00;
      power_r         <= 1'b1;
      brightness_r    <= BRIGHTNESS_DEFAULT;
      mode_r          <= 3'd0;
      speed_r         <= SPEED_DEFAULT;
    end else begin
      keyValid_r      <= applyKey_s;
      configUpdated_r <= applyKey_s && configChanged_s;
      if (applyKey_s) begin
        keyCode_r    <= cmd_s;
        power_r      <= nextPower_s;
        brightness_r <= nextBright_s;
        mode_r       <= nextMode_s;
        speed_r      <= nextSpeed_s;
      end
    end
  end

  // Hold window: reload on a key (wins over a same-cycle tick), else count ms down.
  always_ff @(posedge clkIN or negedge nResetIN) begin
    if (!nResetIN) begin
      holdTimer_r <= 8'd0;
      keyHeld_r   <= 1'b0;
    end else if (applyKey_s) begin
      holdTimer_r <= HOLD_RELOAD;
      keyHeld_r   <= held_s;
    end else if (tick_s && holdTimer_r != 8'd0) begin
      holdTimer_r <= holdTimer_r - 8'd1;
      if (holdTimer_r == 8'd1) keyHeld_r <= 1'b0;
    end
  end

  assign keyValidOUT      = keyValid_r;
  assign keyCodeOUT       = keyCode_r;
  assign keyHeldOUT       = keyHeld_r;
  assign powerOUT         = power_r;
  assign brightnessOUT    = brightness_r;
  assign modeOUT          = mode_r;
  assign speedOUT         = speed_r;
  assign configUpdatedOUT = configUpdated_r;
  assign errorCountOUT    = errorCount_r;

endmodule

// File: tb/tb_nec_ir_controller.sv
// Directed bench for nec_ir_controller with a scoreboard of expected key events.
// CLOCK_KHZ is shrunk to 10 so one "ms" is 10 clocks.
module tb_nec_ir_controller;

  localparam int CLK_KHZ = 10;
  localparam int STEP    = 16;
  localparam int MODES   = 5;

  typedef struct {
    logic [7:0] code;
    logic       held;
    logic       power;
    logic [7:0] bright;
    logic [2:0] mode;
    logic [3:0] speed;
    logic       upd;
  } exp_t;

  logic       clkIN, nResetIN;
  logic       keyValidOUT, keyHeldOUT, powerOUT, configUpdatedOUT;
  logic [7:0] keyCodeOUT, brightnessOUT, errorCountOUT;
  logic [2:0] modeOUT;
  logic [3:0] speedOUT;

  int   compared = 0;
  int   mismatched = 0;
  exp_t expQ[$];
  exp_t got;

  // Reference model state.
  int         mPower, mBright, mMode, mSpeed, mErr;
  logic [7:0] mLastCmd;
  bit         mTimerLive;

  nec_ir_controller_if irBus ();

  nec_ir_controller #(
    .CLOCK_KHZ(CLK_KHZ), .DEVICE_ADDRESS(8'h00), .HOLD_MS(120),
    .BRIGHTNESS_STEP(STEP), .MODE_COUNT(MODES)
  ) dut (
    .clkIN(clkIN), .nResetIN(nResetIN), .irBus(irBus),
    .keyValidOUT(keyValidOUT), .keyCodeOUT(keyCodeOUT), .keyHeldOUT(keyHeldOUT),
    .powerOUT(powerOUT), .brightnessOUT(brightnessOUT), .modeOUT(modeOUT),
    .speedOUT(speedOUT), .configUpdatedOUT(configUpdatedOUT), .errorCountOUT(errorCountOUT)
  );

  initial clkIN = 1'b0;
  always #5 clkIN = ~clkIN;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7 - i];
    return r;
  endfunction

  function automatic logic [31:0] mkFrame(input logic [7:0] a, input logic [7:0] c);
    return {rev8(a), rev8(~a), rev8(c), rev8(~c)};
  endfunction

  task automatic modelReset();
    mPower = 1; mBright = 128; mMode = 0; mSpeed = 8; mErr = 0;
    mLastCmd = 8'h00; mTimerLive = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    check({tag, " keyValid"}, keyValidOUT, 1'b0);
    check({tag, " keyCode"}, keyCodeOUT, 8'h00);
    check({tag, " keyHeld"}, keyHeldOUT, 1'b0);
    check({tag, " power"}, powerOUT, 1'b1);
    check({tag, " brightness"}, brightnessOUT, 8'h80);
    check({tag, " mode"}, modeOUT, 3'd0);
    check({tag, " speed"}, speedOUT, 4'd8);
    check({tag, " configUpdated"}, configUpdatedOUT, 1'b0);
    check({tag, " errorCount"}, errorCountOUT, 8'h00);
  endtask

  // Returns just after the edge that samples the strobe (edge N).
  task automatic sendFrame(input logic [31:0] f);
    @(posedge clkIN); #1;
    irBus.frameIN = f;
    irBus.frameValidIN = 1'b1;
    @(posedge clkIN); #1;
    irBus.frameValidIN = 1'b0;
  endtask

  task automatic sendKey(input logic [7:0] cmd);
    exp_t e;
    bit   held;
    int   op, ob, om, os;
    held = (cmd == mLastCmd) && mTimerLive;
    op = mPower; ob = mBright; om = mMode; os = mSpeed;
    if (cmd == 8'h45) begin
      if (!held) mPower = 1 - mPower;
    end else if (mPower == 1) begin
      case (cmd)
        8'h46: mBright = (mBright + STEP > 255) ? 255 : mBright + STEP;
        8'h15: mBright = (mBright < STEP) ? 0 : mBright - STEP;
        8'h43: if (!held) mMode = (mMode == MODES - 1) ? 0 : mMode + 1;
        8'h44: if (!held) mMode = (mMode == 0) ? MODES - 1 : mMode - 1;
        8'h40: if (mSpeed < 15) mSpeed = mSpeed + 1;
        8'h07: if (mSpeed > 0) mSpeed = mSpeed - 1;
        default: ;
      endcase
    end
    e.code = cmd; e.held = held; e.power = mPower[0]; e.bright = mBright[7:0];
    e.mode = mMode[2:0]; e.speed = mSpeed[3:0];
    e.upd = (op != mPower) || (ob != mBright) || (om != mMode) || (os != mSpeed);
    expQ.push_back(e);
    sendFrame(mkFrame(8'h00, cmd));
    @(posedge clkIN); @(posedge clkIN); #1;
    check("keyValid at N+2", keyValidOUT, 1'b1);
    @(posedge clkIN); #1;
    check("keyValid one cycle", keyValidOUT, 1'b0);
    mLastCmd = cmd;
    mTimerLive = 1'b1;
  endtask

  task automatic sendBad(input logic [31:0] f, input bit counts);
    if (counts && mErr < 255) mErr++;
    sendFrame(f);
    @(posedge clkIN); #1;
    check("errorCount at N+1", errorCountOUT, mErr[7:0]);
    @(posedge clkIN);
  endtask

  // Scoreboard: pop an expectation for each key event the DUT reports.
  always @(negedge clkIN) begin
    if (nResetIN && keyValidOUT) begin
      if (expQ.size() == 0) begin
        check("spurious keyValid", keyValidOUT, 1'b0);
      end else begin
        got = expQ.pop_front();
        check("keyCode", keyCodeOUT, got.code);
        check("keyHeld", keyHeldOUT, got.held);
        check("power", powerOUT, got.power);
        check("brightness", brightnessOUT, got.bright);
        check("mode", modeOUT, got.mode);
        check("speed", speedOUT, got.speed);
        check("configUpdated", configUpdatedOUT, got.upd);
      end
    end else if (nResetIN && configUpdatedOUT) begin
      check("stray configUpdated", configUpdatedOUT, 1'b0);
    end
  end

  initial begin
    nResetIN = 1'b0;
    irBus.frameValidIN = 1'b0;
    irBus.frameIN = 32'h0;
    modelReset();
    repeat (3) @(posedge clkIN); #1;
    checkResetState("reset");
    @(negedge clkIN) nResetIN = 1'b1;
    repeat (2) @(posedge clkIN); #1;

    // First brightness-up frame.
    sendKey(8'h46);
    check("first brightness", brightnessOUT, 8'h90);

    // Repeats every ~108 ms stay inside the 120 ms hold window.
    repeat (2) begin
      repeat (1075) @(posedge clkIN);
      sendKey(8'h46);
    end
    check("held after repeats", keyHeldOUT, 1'b1);
    check("brightness after repeats", brightnessOUT, 8'hB0);
    repeat (1165) @(posedge clkIN); #1;
    check("held before expiry", keyHeldOUT, 1'b1);
    repeat (60) @(posedge clkIN); #1;
    check("held after expiry", keyHeldOUT, 1'b0);
    mTimerLive = 1'b0;

    // Brightness saturation at both ends.
    repeat (6) sendKey(8'h46);
    check("brightness top", brightnessOUT, 8'hFF);
    repeat (17) sendKey(8'h15);
    check("brightness bottom", brightnessOUT, 8'h00);

    // Mode wrap and held-mode suppression.
    sendKey(8'h44);
    check("mode prev wrap", modeOUT, 3'd4);
    repeat (3) sendKey(8'h43);
    check("mode next held", modeOUT, 3'd0);

    // Speed saturation and plain key.
    repeat (8) sendKey(8'h40);
    sendKey(8'h07);
    check("speed", speedOUT, 4'd14);
    sendKey(8'h12);

    // Strobe held across CHECK counts once.
    @(posedge clkIN); #1;
    irBus.frameIN = {rev8(8'h00), rev8(8'hFF), rev8(8'h46), rev8(8'h00)};
    irBus.frameValidIN = 1'b1;
    repeat (2) @(posedge clkIN); #1;
    irBus.frameValidIN = 1'b0;
    mErr = 1;
    repeat (3) @(posedge clkIN); #1;
    check("strobe outside IDLE ignored", errorCountOUT, 8'd1);

    // Complement failures saturate the error counter.
    for (int i = 0; i < 299; i++)
      sendBad({rev8(8'h00), rev8(8'hFF), rev8(8'h46), rev8(8'h00)}, 1'b1);
    check("errorCount saturated", errorCountOUT, 8'hFF);
    mTimerLive = 1'b0;

    // Wrong address: silent.
    sendBad(mkFrame(8'h10, 8'h46), 1'b0);
    check("wrong address brightness", brightnessOUT, 8'h00);

    // Power off blocks config changes.
    sendKey(8'h45);
    check("power off", powerOUT, 1'b0);
    sendKey(8'h40);
    check("speed while off", speedOUT, 4'd14);

    // Reset while a frame is in CHECK.
    sendFrame(mkFrame(8'h00, 8'h45));
    nResetIN = 1'b0;
    modelReset();
    #1;
    checkResetState("reset in CHECK");
    repeat (2) @(posedge clkIN);
    @(negedge clkIN) nResetIN = 1'b1;
    repeat (6) @(posedge clkIN); #1;
    checkResetState("after reset release");

    check("scoreboard drained", expQ.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
